mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single memory bus between instruction fetch (IF) and the memory stage (DM), one request/ack handshake at a time.
// Sits between the pipeline and the memory model: word-aligns addresses, generates store byte strobes and lane-shifted write data,
// and returns sign/zero-extended load data. Owns misalignment detection and a bus timeout so neither pipeline stage hangs.
// PARAMETERS
// XLEN            32   data/address width (from header.vh)
// TIMEOUT_CYCLES  255  cycles in BUSY without i_mem_ack before abort; 0 disables timeout
// PORTS
// i_clk          in   1     CPU clock
// i_rst          in   1     synchronous active-high reset
// i_if_req       in   1     fetch request, level, held until o_if_ack
// i_if_addr      in   XLEN  fetch byte address
// or_if_ack      out  1     one-cycle completion pulse to fetch
// or_if_data     out  XLEN  instruction word, valid with or_if_ack
// or_if_err      out  1     fetch misaligned/timeout, valid with or_if_ack
// i_dm_req       in   1     data request, level, held until or_dm_ack
// i_dm_addr      in   XLEN  data byte address
// i_dm_we        in   1     0 load, 1 store
// i_dm_funct3    in   3     LB/LH/LW/LBU/LHU or SB/SH/SW encoding
// i_dm_wdata     in   XLEN  store data, LSB-justified
// or_dm_ack      out  1     one-cycle completion pulse to memory stage
// or_dm_rdata    out  XLEN  extended load data, valid with or_dm_ack (0 for stores)
// or_dm_err      out  1     data misaligned/timeout, valid with or_dm_ack
// or_mem_req     out  1     bus request, held until i_mem_ack or abort
// or_mem_addr    out  XLEN  word address {addr[XLEN-1:2],2'b00}
// or_mem_we      out  1     bus write enable
// or_mem_wstrb   out  4     byte strobes (writes only; 0 on reads)
// or_mem_wdata   out  XLEN  lane-shifted store data
// i_mem_ack      in   1     bus completion, sampled only in BUSY
// i_mem_rdata    in   XLEN  bus read word, valid with i_mem_ack
// BEHAVIOUR
// - Reset (sync, i_rst=1 at edge): state IDLE, last_grant=IF, timeout count 0, every output 0. Mid-transaction reset drops
//   or_mem_req next edge; no ack is issued for the killed transaction; a late i_mem_ack afterwards is ignored.
// - FSM: IDLE -> BUSY (valid aligned request granted) | RESP (misaligned request granted; no bus cycle);
//   BUSY -> RESP on i_mem_ack or timeout; RESP -> IDLE. RESP is exactly one cycle with the owner's ack pulsed.
// - Arbitration in IDLE: one requester -> it wins; both -> the one NOT in last_grant wins (round robin); last_grant updates on grant.
// - Latency: request seen at edge N (IDLE) -> or_mem_req=1 from N+1; i_mem_ack at edge M -> ack/data/err at M+1, or_mem_req=0 at M+1;
//   next grant decided at M+2 earliest. Minimum turnaround: 3 cycles per transaction with zero-wait memory.
// - Bus outputs constant throughout BUSY; captured at grant, never re-sampled from requester.
// - Granted transaction is committed: requester dropping req (flush) does not cancel it; ack still pulses, requester ignores it.
// - Misalignment: LH/LHU/SH addr[0]=1, LW/SW/fetch addr[1:0]!=0 -> err=1, ack one cycle after grant, rdata 0, no bus request.
//   Unsupported funct3 treated as misaligned error.
// - Stores: SB wstrb=1<<addr[1:0], data byte replicated to lane; SH wstrb=addr[1]?1100:0011; SW wstrb=1111, data unchanged.
// - Loads: lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged. Fetch returns word unchanged.
// - Timeout: counter increments each BUSY cycle, clears on leaving BUSY; reaching TIMEOUT_CYCLES -> or_mem_req=0, ack+err=1.
// - or_if_ack and or_dm_ack never high in the same cycle.
// STRUCTURE
// - header.vh: XLEN, funct3 encodings (F3_B/H/W/BU/HU), arbiter state encodings, TIMEOUT default.
// - Sub-module mem_lane_align (combinational): store strobe/lane shift, load extract/extend, misalignment flag.
// - Top: FSM, round-robin pointer, capture registers, timeout counter, response registers.
// TESTING
// - Fetch only, addr 0x100, memory acks 2 cycles after req, rdata 0x00500093 -> or_mem_addr=0x100, or_if_ack 1 cycle, or_if_data=0x00500093.
// - Both req same cycle after reset (last_grant=IF) -> DM served first, then IF; repeat both -> alternates DM,IF,DM,IF.
// - SB addr 0x203, wdata 0xAB -> or_mem_addr=0x200, wstrb=1000, wdata[31:24]=0xAB; LB addr 0x203, rdata 0x80xxxxxx -> 0xFFFFFF80; LBU -> 0x00000080.
// - LW addr 0x302 -> no or_mem_req, or_dm_ack+or_dm_err one cycle after grant, rdata 0; IF request pending is served next.
// - TIMEOUT_CYCLES=4, no i_mem_ack -> or_mem_req drops after 4 BUSY cycles, or_if_ack+or_if_err pulse; later stray ack ignored.
// - i_rst asserted mid-BUSY -> all outputs 0 next edge, no ack; fresh request afterward completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM memory port arbiter: widths, funct3 encodings,
// FSM state and owner types.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-lane logic: store strobes and lane-replicated write data,
// load lane extraction with sign/zero extension, and misalignment detection.
module mem_port_arbiter_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic            i_is_fetch,
    input  logic            i_we,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_lane,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_misalign,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_lane, 3'b000};

    always_comb begin
        o_misalign = 1'b0;
        o_wstrb    = '0;
        o_wdata    = '0;
        o_rdata    = '0;
        if (i_is_fetch) begin
            o_misalign = |i_lane;
            o_rdata    = i_rdata;
        end else if (i_we) begin
            unique case (i_funct3)
                F3_B: begin
                    o_wstrb = 4'b0001 << i_lane;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                F3_H: begin
                    o_misalign = i_lane[0];
                    o_wstrb    = i_lane[1] ? 4'b1100 : 4'b0011;
                    o_wdata    = {2{i_wdata[15:0]}};
                end
                F3_W: begin
                    o_misalign = |i_lane;
                    o_wstrb    = 4'b1111;
                    o_wdata    = i_wdata;
                end
                default: o_misalign = 1'b1;
            endcase
        end else begin
            unique case (i_funct3)
                F3_B:  o_rdata = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
                F3_BU: o_rdata = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
                F3_H: begin
                    o_misalign = i_lane[0];
                    o_rdata    = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
                end
                F3_HU: begin
                    o_misalign = i_lane[0];
                    o_rdata    = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
                end
                F3_W: begin
                    o_misalign = |i_lane;
                    o_rdata    = i_rdata;
                end
                default: o_misalign = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one request/ack memory bus between instruction fetch
// and the memory stage, with misalignment rejection and a BUSY timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            or_if_ack,
    output logic [XLEN-1:0] or_if_data,
    output logic            or_if_err,
    input  logic            i_dm_req,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic            i_dm_we,
    input  logic [2:0]      i_dm_funct3,
    input  logic [XLEN-1:0] i_dm_wdata,
    output logic            or_dm_ack,
    output logic [XLEN-1:0] or_dm_rdata,
    output logic            or_dm_err,
    output logic            or_mem_req,
    output logic [XLEN-1:0] or_mem_addr,
    output logic            or_mem_we,
    output logic [3:0]      or_mem_wstrb,
    output logic [XLEN-1:0] or_mem_wdata,
    input  logic            i_mem_ack,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam int unsigned    TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_t      r_state, w_state_nxt;
    owner_t          r_last, r_owner;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [TW-1:0]   r_tmo;

    logic            w_pick_dm, w_grant, w_finish, w_tmo_hit;
    logic [XLEN-1:0] w_sel_addr;
    logic            w_al_fetch, w_al_we, w_misalign;
    logic [2:0]      w_al_f3;
    logic [1:0]      w_al_lane;
    logic [3:0]      w_al_wstrb;
    logic [XLEN-1:0] w_al_wdata, w_al_rdata;

    assign w_pick_dm  = i_dm_req & (~i_if_req | (r_last == OWN_IF));
    assign w_sel_addr = w_pick_dm ? i_dm_addr : i_if_addr;

    // In IDLE the aligner looks at the candidate request; afterwards at the captured one.
    assign w_al_fetch = (r_state == ST_IDLE) ? ~w_pick_dm            : (r_owner == OWN_IF);
    assign w_al_we    = (r_state == ST_IDLE) ? (w_pick_dm & i_dm_we) : r_we;
    assign w_al_f3    = (r_state == ST_IDLE) ? i_dm_funct3           : r_funct3;
    assign w_al_lane  = (r_state == ST_IDLE) ? w_sel_addr[1:0]       : r_lane;

    mem_port_arbiter_lane_align u_align (
        .i_is_fetch (w_al_fetch),
        .i_we       (w_al_we),
        .i_funct3   (w_al_f3),
        .i_lane     (w_al_lane),
        .i_wdata    (i_dm_wdata),
        .i_rdata    (i_mem_rdata),
        .o_misalign (w_misalign),
        .o_wstrb    (w_al_wstrb),
        .o_wdata    (w_al_wdata),
        .o_rdata    (w_al_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        w_tmo_hit   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_if_req || i_dm_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = w_misalign ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_mem_ack) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_tmo == TMO_LAST)) begin
                    w_finish    = 1'b1;
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last       <= OWN_IF;
            r_owner      <= OWN_IF;
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_lane       <= '0;
            r_tmo        <= '0;
            or_if_ack    <= 1'b0;
            or_if_data   <= '0;
            or_if_err    <= 1'b0;
            or_dm_ack    <= 1'b0;
            or_dm_rdata  <= '0;
            or_dm_err    <= 1'b0;
            or_mem_req   <= 1'b0;
            or_mem_addr  <= '0;
            or_mem_we    <= 1'b0;
            or_mem_wstrb <= '0;
            or_mem_wdata <= '0;
        end else begin
            or_if_ack   <= 1'b0;
            or_if_data  <= '0;
            or_if_err   <= 1'b0;
            or_dm_ack   <= 1'b0;
            or_dm_rdata <= '0;
            or_dm_err   <= 1'b0;
            if (w_grant) begin
                r_last   <= w_pick_dm ? OWN_DM : OWN_IF;
                r_owner  <= w_pick_dm ? OWN_DM : OWN_IF;
                r_we     <= w_al_we;
                r_funct3 <= i_dm_funct3;
                r_lane   <= w_al_lane;
                if (w_misalign) begin
                    or_if_ack <= ~w_pick_dm;
                    or_if_err <= ~w_pick_dm;
                    or_dm_ack <= w_pick_dm;
                    or_dm_err <= w_pick_dm;
                end else begin
                    or_mem_req   <= 1'b1;
                    or_mem_addr  <= {w_sel_addr[XLEN-1:2], 2'b00};
                    or_mem_we    <= w_al_we;
                    or_mem_wstrb <= w_al_we ? w_al_wstrb : 4'b0000;
                    or_mem_wdata <= w_al_we ? w_al_wdata : '0;
                end
            end
            if (w_finish) begin
                r_tmo        <= '0;
                or_mem_req   <= 1'b0;
                or_mem_addr  <= '0;
                or_mem_we    <= 1'b0;
                or_mem_wstrb <= '0;
                or_mem_wdata <= '0;
                if (r_owner == OWN_IF) begin
                    or_if_ack  <= 1'b1;
                    or_if_err  <= w_tmo_hit;
                    or_if_data <= w_tmo_hit ? '0 : w_al_rdata;
                end else begin
                    or_dm_ack   <= 1'b1;
                    or_dm_err   <= w_tmo_hit;
                    or_dm_rdata <= (w_tmo_hit || r_we) ? '0 : w_al_rdata;
                end
            end else if (r_state == ST_BUSY) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: expected responses are queued as
// requests are driven and checked when the bus transaction and ack occur.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [2:0]  dm_f3;
    logic        if_ack, if_err, dm_ack, dm_err, mem_req, mem_we;
    logic [31:0] if_data, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          dm;
        bit          bus;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  strb;
        logic [31:0] wdata_m;
        logic [31:0] rd_in;
        int          delay;
        logic [31:0] data;
        bit          err;
    } item_t;

    item_t sb[$];

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .or_if_ack    (if_ack),
        .or_if_data   (if_data),
        .or_if_err    (if_err),
        .i_dm_req     (dm_req),
        .i_dm_addr    (dm_addr),
        .i_dm_we      (dm_we),
        .i_dm_funct3  (dm_f3),
        .i_dm_wdata   (dm_wdata),
        .or_dm_ack    (dm_ack),
        .or_dm_rdata  (dm_rdata),
        .or_dm_err    (dm_err),
        .or_mem_req   (mem_req),
        .or_mem_addr  (mem_addr),
        .or_mem_we    (mem_we),
        .or_mem_wstrb (mem_wstrb),
        .or_mem_wdata (mem_wdata),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_if(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic drive_dm(input logic [31:0] a, input logic we, input logic [2:0] f3, input logic [31:0] wd);
        dm_req   = 1'b1;
        dm_addr  = a;
        dm_we    = we;
        dm_f3    = f3;
        dm_wdata = wd;
    endtask

    task automatic push(input bit dm, input bit bus, input logic [31:0] addr, input bit we,
                        input logic [3:0] strb, input logic [31:0] wdm, input logic [31:0] rd_in,
                        input int delay, input logic [31:0] data, input bit err);
        item_t it;
        it.dm = dm; it.bus = bus; it.addr = addr; it.we = we; it.strb = strb;
        it.wdata_m = wdm; it.rd_in = rd_in; it.delay = delay; it.data = data; it.err = err;
        sb.push_back(it);
    endtask

    // Serve the oldest queued transaction on the bus and check the response it produces.
    task automatic run_one();
        item_t       it;
        int          n;
        logic [31:0] m;
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        it = sb.pop_front();
        if (it.bus) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!mem_req && n < 8);
            check("req_latency", n, 1);
            m = {{8{it.strb[3]}}, {8{it.strb[2]}}, {8{it.strb[1]}}, {8{it.strb[0]}}};
            check("bus_addr", mem_addr, it.addr);
            check("bus_we", {31'd0, mem_we}, {31'd0, it.we});
            check("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, it.strb});
            check("bus_wdata", mem_wdata & m, it.wdata_m);
            if (it.delay >= 0) begin
                repeat (it.delay) begin
                    tick();
                    check("bus_hold_req", {31'd0, mem_req}, 32'd1);
                    check("bus_hold_addr", mem_addr, it.addr);
                end
                mem_ack   = 1'b1;
                mem_rdata = it.rd_in;
                tick();
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end else begin
                n = 1;
                tick();
                while (mem_req && n < 20) begin
                    n++;
                    tick();
                end
                check("tmo_busy_cycles", n, TMO);
            end
        end else begin
            tick();
        end
        check("req_dropped", {31'd0, mem_req}, 32'd0);
        check("owner_ack", {31'd0, it.dm ? dm_ack : if_ack}, 32'd1);
        check("other_ack", {31'd0, it.dm ? if_ack : dm_ack}, 32'd0);
        check("resp_data", it.dm ? dm_rdata : if_data, it.data);
        check("resp_err", {31'd0, it.dm ? dm_err : if_err}, {31'd0, it.err});
        if (it.dm) dm_req = 1'b0;
        else       if_req = 1'b0;
        tick();
        check("ack_one_cycle", {30'd0, if_ack, dm_ack}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; dm_f3 = '0;
        repeat (2) tick();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        rst = 1'b0;
        tick();

        // Plain fetch with a two-cycle memory wait.
        drive_if(32'h100);
        push(0, 1, 32'h100, 0, 4'b0000, 0, 32'h0050_0093, 2, 32'h0050_0093, 0);
        run_one();

        // Simultaneous requests after an IF grant: DM first, then alternate.
        for (int r = 0; r < 3; r++) begin
            drive_dm(32'h400 + 32'(r * 8), 1'b0, F3_W, 32'h0);
            drive_if(32'h104 + 32'(r * 8));
            push(1, 1, 32'h400 + 32'(r * 8), 0, 4'b0000, 0, 32'h1122_3340 + 32'(r), 0, 32'h1122_3340 + 32'(r), 0);
            push(0, 1, 32'h104 + 32'(r * 8), 0, 4'b0000, 0, 32'hAAAA_0000 + 32'(r), 1, 32'hAAAA_0000 + 32'(r), 0);
            run_one();
            run_one();
        end

        // Stores.
        drive_dm(32'h203, 1'b1, F3_B, 32'h0000_00AB);
        push(1, 1, 32'h200, 1, 4'b1000, 32'hAB00_0000, 32'h0, 0, 32'h0, 0);
        run_one();
        drive_dm(32'h202, 1'b1, F3_H, 32'h0000_1234);
        push(1, 1, 32'h200, 1, 4'b1100, 32'h1234_0000, 32'h0, 1, 32'h0, 0);
        run_one();
        drive_dm(32'h204, 1'b1, F3_W, 32'hDEAD_BEEF);
        push(1, 1, 32'h204, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0, 32'h0, 0);
        run_one();

        // Loads with lane extraction and extension.
        drive_dm(32'h203, 1'b0, F3_B, 32'h0);
        push(1, 1, 32'h200, 0, 4'b0000, 0, 32'h8012_3456, 0, 32'hFFFF_FF80, 0);
        run_one();
        drive_dm(32'h203, 1'b0, F3_BU, 32'h0);
        push(1, 1, 32'h200, 0, 4'b0000, 0, 32'h8012_3456, 0, 32'h0000_0080, 0);
        run_one();
        drive_dm(32'h202, 1'b0, F3_H, 32'h0);
        push(1, 1, 32'h200, 0, 4'b0000, 0, 32'h8001_5555, 0, 32'hFFFF_8001, 0);
        run_one();
        drive_dm(32'h202, 1'b0, F3_HU, 32'h0);
        push(1, 1, 32'h200, 0, 4'b0000, 0, 32'h8001_5555, 0, 32'h0000_8001, 0);
        run_one();
        drive_dm(32'h201, 1'b0, F3_B, 32'h0);
        push(1, 1, 32'h200, 0, 4'b0000, 0, 32'h1234_7F56, 0, 32'h0000_007F, 0);
        run_one();

        // Misaligned LW with a fetch pending; a fetch first puts last_grant on IF.
        drive_if(32'h10C);
        push(0, 1, 32'h10C, 0, 4'b0000, 0, 32'h0000_0013, 0, 32'h0000_0013, 0);
        run_one();
        drive_dm(32'h302, 1'b0, F3_W, 32'h0);
        drive_if(32'h108);
        push(1, 0, 32'h0, 0, 4'b0000, 0, 32'h0, 0, 32'h0, 1);
        push(0, 1, 32'h108, 0, 4'b0000, 0, 32'h1357_9BDF, 0, 32'h1357_9BDF, 0);
        run_one();
        run_one();

        // Other error sources.
        drive_dm(32'h201, 1'b0, F3_H, 32'h0);
        push(1, 0, 32'h0, 0, 4'b0000, 0, 32'h0, 0, 32'h0, 1);
        run_one();
        drive_dm(32'h200, 1'b0, 3'b011, 32'h0);
        push(1, 0, 32'h0, 0, 4'b0000, 0, 32'h0, 0, 32'h0, 1);
        run_one();
        drive_dm(32'h206, 1'b1, F3_W, 32'h1111_2222);
        push(1, 0, 32'h0, 0, 4'b0000, 0, 32'h0, 0, 32'h0, 1);
        run_one();
        drive_if(32'h102);
        push(0, 0, 32'h0, 0, 4'b0000, 0, 32'h0, 0, 32'h0, 1);
        run_one();

        // Timeout, then a stray ack that must be ignored.
        drive_if(32'h120);
        push(0, 1, 32'h120, 0, 4'b0000, 0, 32'h0, -1, 32'h0, 1);
        run_one();
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("stray_ack_no_resp", {30'd0, if_ack, dm_ack}, 32'd0);
        check("stray_ack_no_req", {31'd0, mem_req}, 32'd0);

        // Reset in the middle of BUSY kills the transaction silently.
        drive_dm(32'h500, 1'b0, F3_W, 32'h0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_req && n < 8);
        check("mid_rst_busy_seen", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        rst = 1'b0; dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("post_rst_late_ack", {30'd0, if_ack, dm_ack}, 32'd0);
        tick();
        check("post_rst_idle", {29'd0, mem_req, if_ack, dm_ack}, 32'd0);

        drive_dm(32'h504, 1'b0, F3_W, 32'h0);
        push(1, 1, 32'h504, 0, 4'b0000, 0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0);
        run_one();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
